// File: rtl/writeback_stage_if.sv
// Bundle between the memory stage and the writeback stage: registered memory-stage
// outputs and ecall completion in, register-file / store-commit / ecall signals out.
interface writeback_stage_if #(
  parameter int REG_WIDTH = 64
);
  logic [31:0]          wb_instrux;
  logic [63:0]          wb_pc;
  logic                 wb_is_inst_valid;
  logic                 wb_is_inst_regwrite;
  logic                 wb_is_mem_to_reg;
  logic [4:0]           wb_reg;
  logic [REG_WIDTH-1:0] wb_result;
  logic [REG_WIDTH-1:0] wb_ld_result;
  logic [2:0]           wb_dpw_size;
  logic [63:0]          wb_dpw_addr;
  logic [63:0]          wb_dpw_val;
  logic                 wb_dpw_is_inst_memwrite;
  logic                 wb_is_ecall_inst;
  logic                 ecall_done;
  logic [REG_WIDTH-1:0] ecall_ret;

  logic                 owb_rf_we;
  logic [4:0]           owb_rf_waddr;
  logic [REG_WIDTH-1:0] owb_rf_wdata;
  logic                 owb_dpw_req;
  logic [63:0]          owb_dpw_addr;
  logic [63:0]          owb_dpw_val;
  logic [2:0]           owb_dpw_size;
  logic                 owb_ecall_req;
  logic [63:0]          owb_ecall_pc;
  logic                 owb_stall;
  logic [63:0]          owb_retired;

  modport slave (
    input  wb_instrux, wb_pc, wb_is_inst_valid, wb_is_inst_regwrite, wb_is_mem_to_reg,
           wb_reg, wb_result, wb_ld_result, wb_dpw_size, wb_dpw_addr, wb_dpw_val,
           wb_dpw_is_inst_memwrite, wb_is_ecall_inst, ecall_done, ecall_ret,
    output owb_rf_we, owb_rf_waddr, owb_rf_wdata, owb_dpw_req, owb_dpw_addr, owb_dpw_val,
           owb_dpw_size, owb_ecall_req, owb_ecall_pc, owb_stall, owb_retired
  );

  modport master (
    output wb_instrux, wb_pc, wb_is_inst_valid, wb_is_inst_regwrite, wb_is_mem_to_reg,
           wb_reg, wb_result, wb_ld_result, wb_dpw_size, wb_dpw_addr, wb_dpw_val,
           wb_dpw_is_inst_memwrite, wb_is_ecall_inst, ecall_done, ecall_ret,
    input  owb_rf_we, owb_rf_waddr, owb_rf_wdata, owb_dpw_req, owb_dpw_addr, owb_dpw_val,
           owb_dpw_size, owb_ecall_req, owb_ecall_pc, owb_stall, owb_retired
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: load extension, register-file write, store commit pulses,
// and a request/done ecall handshake that stalls upstream while outstanding.
module writeback_stage #(
  parameter int REG_WIDTH = 64,
  parameter int A0_REG    = 10
) (
  input  logic              clk,
  input  logic              reset,
  writeback_stage_if.slave  bus
);

  localparam logic [0:0] RUN        = 1'b0;
  localparam logic [0:0] ECALL_WAIT = 1'b1;
  localparam logic [4:0] A0_ADDR    = 5'(A0_REG);

  logic [0:0]           state_q, state_d;
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [REG_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                 dpw_req_q, dpw_req_d;
  logic [63:0]          dpw_addr_q, dpw_addr_d;
  logic [63:0]          dpw_val_q, dpw_val_d;
  logic [2:0]           dpw_size_q, dpw_size_d;
  logic                 ecall_req_q, ecall_req_d;
  logic [63:0]          ecall_pc_q, ecall_pc_d;
  logic [63:0]          retired_q, retired_d;

  logic [2:0]           funct3;
  logic [REG_WIDTH-1:0] ld_ext;
  logic [REG_WIDTH-1:0] wdata_sel;
  logic                 run_valid;
  logic                 take_ecall;
  logic                 take_plain;
  logic                 rf_fire;
  logic                 done_fire;
  logic                 unused_instrux;

  assign funct3         = bus.wb_instrux[14:12];
  assign unused_instrux = ^{bus.wb_instrux[31:15], bus.wb_instrux[11:0]};

  always_comb begin
    ld_ext = '0;
    case (funct3)
      3'b000:  ld_ext = {{(REG_WIDTH-8){bus.wb_ld_result[7]}},   bus.wb_ld_result[7:0]};
      3'b001:  ld_ext = {{(REG_WIDTH-16){bus.wb_ld_result[15]}}, bus.wb_ld_result[15:0]};
      3'b010:  ld_ext = {{(REG_WIDTH-32){bus.wb_ld_result[31]}}, bus.wb_ld_result[31:0]};
      3'b011:  ld_ext = bus.wb_ld_result;
      3'b100:  ld_ext = {{(REG_WIDTH-8){1'b0}},  bus.wb_ld_result[7:0]};
      3'b101:  ld_ext = {{(REG_WIDTH-16){1'b0}}, bus.wb_ld_result[15:0]};
      3'b110:  ld_ext = {{(REG_WIDTH-32){1'b0}}, bus.wb_ld_result[31:0]};
      default: ld_ext = '0;
    endcase
  end

  assign wdata_sel = bus.wb_is_mem_to_reg ? ld_ext : bus.wb_result;

  // Every action below is qualified by RUN, so inputs held during ECALL_WAIT are inert.
  assign run_valid  = (state_q == RUN) && bus.wb_is_inst_valid;
  assign take_ecall = run_valid && bus.wb_is_ecall_inst;
  assign take_plain = run_valid && !bus.wb_is_ecall_inst;
  assign rf_fire    = take_plain && bus.wb_is_inst_regwrite && (bus.wb_reg != 5'd0)
                      && !(bus.wb_is_mem_to_reg && (funct3 == 3'b111));
  assign done_fire  = (state_q == ECALL_WAIT) && bus.ecall_done;

  always_comb begin
    state_d     = state_q;
    rf_we_d     = rf_fire || done_fire;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    dpw_req_d   = take_plain && bus.wb_dpw_is_inst_memwrite;
    dpw_addr_d  = dpw_addr_q;
    dpw_val_d   = dpw_val_q;
    dpw_size_d  = dpw_size_q;
    ecall_req_d = ecall_req_q;
    ecall_pc_d  = ecall_pc_q;
    retired_d   = retired_q + {63'd0, (take_plain || done_fire)};

    if (done_fire) begin
      rf_waddr_d = A0_ADDR;
      rf_wdata_d = bus.ecall_ret;
    end else if (rf_fire) begin
      rf_waddr_d = bus.wb_reg;
      rf_wdata_d = wdata_sel;
    end

    if (dpw_req_d) begin
      dpw_addr_d = bus.wb_dpw_addr;
      dpw_val_d  = bus.wb_dpw_val;
      dpw_size_d = bus.wb_dpw_size;
    end

    case (state_q)
      RUN: begin
        if (take_ecall) begin
          state_d     = ECALL_WAIT;
          ecall_req_d = 1'b1;
          ecall_pc_d  = bus.wb_pc;
        end
      end
      ECALL_WAIT: begin
        if (bus.ecall_done) begin
          state_d     = RUN;
          ecall_req_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      dpw_req_q   <= 1'b0;
      dpw_addr_q  <= '0;
      dpw_val_q   <= '0;
      dpw_size_q  <= '0;
      ecall_req_q <= 1'b0;
      ecall_pc_q  <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      dpw_req_q   <= dpw_req_d;
      dpw_addr_q  <= dpw_addr_d;
      dpw_val_q   <= dpw_val_d;
      dpw_size_q  <= dpw_size_d;
      ecall_req_q <= ecall_req_d;
      ecall_pc_q  <= ecall_pc_d;
      retired_q   <= retired_d;
    end
  end

  assign bus.owb_stall     = take_ecall || ((state_q == ECALL_WAIT) && !bus.ecall_done);
  assign bus.owb_rf_we     = rf_we_q;
  assign bus.owb_rf_waddr  = rf_waddr_q;
  assign bus.owb_rf_wdata  = rf_wdata_q;
  assign bus.owb_dpw_req   = dpw_req_q;
  assign bus.owb_dpw_addr  = dpw_addr_q;
  assign bus.owb_dpw_val   = dpw_val_q;
  assign bus.owb_dpw_size  = dpw_size_q;
  assign bus.owb_ecall_req = ecall_req_q;
  assign bus.owb_ecall_pc  = ecall_pc_q;
  assign bus.owb_retired   = retired_q;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage, directly downstream of the memory stage; consumes the memory stage's registered outputs.
- Selects the ALU result or the load data, then sign- or zero-extends loads per funct3.
- Drives the integer register file write port and the forwarding value.
- Issues pending-store commit pulses.
- Serialises ecalls with a request/done handshake, stalling upstream while an ecall is outstanding.

Parameters:
REG_WIDTH, 64, datapath width
A0_REG, 10, register number receiving the ecall return value

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
wb_instrux  in  32  instruction; funct3 = [14:12]
wb_pc  in  64  instruction PC
wb_is_inst_valid  in  1  slot holds a real instruction
wb_is_inst_regwrite  in  1  instruction writes rd
wb_is_mem_to_reg  in  1  rd data comes from load data
wb_reg  in  5  rd number
wb_result  in  REG_WIDTH  ALU result
wb_ld_result  in  REG_WIDTH  raw load data, right-aligned at bit 0
wb_dpw_size  in  3  store size code
wb_dpw_addr  in  64  store address
wb_dpw_val  in  64  store data
wb_dpw_is_inst_memwrite  in  1  instruction is a store
wb_is_ecall_inst  in  1  instruction is ecall
ecall_done  in  1  ecall handler completion, single-cycle pulse
ecall_ret  in  REG_WIDTH  ecall return value, valid with ecall_done
owb_rf_we  out  1  register file write enable
owb_rf_waddr  out  5  register file write address
owb_rf_wdata  out  REG_WIDTH  register file write data
owb_dpw_req  out  1  store commit pulse
owb_dpw_addr  out  64  store commit address
owb_dpw_val  out  64  store commit data
owb_dpw_size  out  3  store commit size
owb_ecall_req  out  1  ecall request level
owb_ecall_pc  out  64  PC of the ecall
owb_stall  out  1  hold upstream registers (combinational)
owb_retired  out  64  retired instruction counter

Behaviour:
- Reset (async, active-high): state = RUN; every registered output = 0, including owb_retired.
- All outputs except owb_stall are registered: inputs sampled at edge T appear at T+1.
- States:
  - RUN:
    - Valid non-ecall instruction at T → its results appear at T+1.
    - Valid ecall at T → state ECALL_WAIT at T+1.
  - ECALL_WAIT:
    - All data inputs are ignored (upstream holds them).
    - ecall_done = 1 at D → state RUN at D+1.
    - ecall_done is ignored while in RUN.
- owb_stall = (RUN & wb_is_inst_valid & wb_is_ecall_inst) | (ECALL_WAIT & ~ecall_done).
- Load extension, applied when wb_is_mem_to_reg = 1, selected by funct3:
  - 000: sign-extend bits [7:0]
  - 001: sign-extend bits [15:0]
  - 010: sign-extend bits [31:0]
  - 011: full 64 bits
  - 100: zero-extend bits [7:0]
  - 101: zero-extend bits [15:0]
  - 110: zero-extend bits [31:0]
  - 111: data 0, no write
- wdata = extended load data if wb_is_mem_to_reg = 1, else wb_result.
- Register write, RUN, T → T+1:
  - owb_rf_we = valid & regwrite & ~ecall & (wb_reg ≠ 0) & ~(mem_to_reg & funct3 = 111).
  - Writes to x0 are always suppressed.
  - waddr/wdata are updated only when the write fires; otherwise they hold their previous values.
- Store commit: RUN with valid & memwrite & ~ecall → owb_dpw_req = 1 at T+1 for exactly one cycle, with addr/val/size copied from the inputs.
- Ecall sequence:
  - Entering ECALL_WAIT: owb_ecall_req = 1 and owb_ecall_pc = wb_pc from T+1.
  - owb_ecall_req holds until the edge after ecall_done.
  - At D+1: owb_ecall_req = 0, owb_rf_we = 1, waddr = A0_REG, wdata = ecall_ret.
- owb_retired increments by 1 at T+1 for each valid non-ecall instruction in RUN, and at D+1 for each ecall. It wraps modulo 2^64.
- Invalid slots produce no write, no store and no count.
- Single-cycle pulses: owb_rf_we and owb_dpw_req are 1 only for their one cycle; 0 otherwise.
- Reset mid-ecall: immediate return to RUN, owb_ecall_req = 0, owb_stall = 0, no a0 write.
- ecall_done in the same cycle as entering ECALL_WAIT (edge T) is ignored; only ecall_done sampled while in ECALL_WAIT counts.

Test Plan:
- Load sign handling:
  - funct3 = 000, ld_result = 0x80, rd = 5 → next cycle we = 1, waddr = 5, wdata = 0xFFFFFFFFFFFFFF80.
  - Same with funct3 = 100 → wdata = 0x80.
  - funct3 = 010, ld_result = 0x00000000_8000_0001 → wdata = 0xFFFFFFFF80000001.
- ALU write to x0: regwrite = 1, rd = 0, result = 0x1234 → we stays 0; owb_retired increments by 1.
- Store: memwrite, addr = 0x1000, val = 0xAB, size = 0 → owb_dpw_req = 1 for exactly one cycle with addr 0x1000, val 0xAB, size 0; no register write.
- Ecall handshake: ecall at T → stall = 1 at T; ecall_req = 1 from T+1; ecall_done with ret = 7 at T+4 → stall = 0 at T+4; at T+5 we = 1, waddr = 10, wdata = 7, ecall_req = 0, retired + 1.
- Reset asserted mid-ECALL_WAIT (asynchronously, between edges) → owb_ecall_req and owb_stall drop without waiting for an edge; no a0 write; owb_retired = 0.
- Back-to-back: 3 valid ALU ops then an invalid bubble → three consecutive we pulses; counter reads 3; the bubble causes no write.
